mem_sys: RTL

- Parametrised Harvard memory subsystem: one instruction channel (IM) and one data channel (DM), each backed by its own on-chip word array.
- Successor to the fixed single-cycle IM/DM SRAM hookup. Adds valid/grant handshakes, configurable wait states per channel, byte-lane writes, and an IM loader port.
- Sits between the cpu pipeline (fetch and MEM stages) and storage. The cpu stalls on grant and response.

---
 rtl/mem_sys_pkg.sv | 21 ++
 rtl/mem_chan.sv | 122 ++++++++++++
 rtl/mem_sys.sv | 102 ++++++++++
 3 files changed

// File: rtl/mem_sys_pkg.sv
// Shared types and constants for the mem_sys Harvard memory subsystem.
// MEM_SYS_PERF_EN enables the completion counters that use sat_inc.
package mem_sys_pkg;

  localparam int unsigned LAT_W      = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned PERF_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } chan_state_e;

  // Saturating increment for the completion counters
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/mem_chan.sv
// One memory channel: IDLE/WAIT/RESP handshake FSM, wait-state counter, word array
// with byte-lane writes and a priority external write port. MEM_SYS_PERF_EN adds completion strobes.
module mem_chan
  import mem_sys_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  hold,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  ext_we,
  input  logic [ADDR_W-1:0]     ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  output logic                  gnt,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     rdata
`ifdef MEM_SYS_PERF_EN
  ,
  output logic                  done_rd_c,
  output logic                  done_wr_c
`endif
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam bit          ZERO_LAT = (LAT == 0);
  localparam logic [LAT_W-1:0] LAT_V = LAT_W'(LAT);

  chan_state_e       state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, access;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [NB-1:0]     acc_be;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // Zero wait states access on the accept edge itself, so use the live request
  assign acc_addr  = ZERO_LAT ? addr  : addr_q;
  assign acc_we    = ZERO_LAT ? we    : we_q;
  assign acc_be    = ZERO_LAT ? be    : be_q;
  assign acc_wdata = ZERO_LAT ? wdata : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        gnt     = req & ~hold & ~rst;
        state_d = IDLE;
        if (gnt) begin
          accept  = 1'b1;
          cnt_d   = LAT_V;
          state_d = ZERO_LAT ? RESP : WAIT;
          access  = ZERO_LAT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rvalid  <= access;
      if (accept) begin
        addr_q  <= addr;
        we_q    <= we;
        be_q    <= be;
        wdata_q <= wdata;
      end
      if (access && !acc_we) rdata <= mem[acc_addr];
    end
  end

  // Array is not reset; external writes land last so they win a same-address collision
  always_ff @(posedge clk) begin
    if (access && acc_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (acc_be[i]) mem[acc_addr][i*8 +: 8] <= acc_wdata[i*8 +: 8];
      end
    end
    if (ext_we) mem[ext_addr] <= ext_wdata;
  end

`ifdef MEM_SYS_PERF_EN
  assign done_rd_c = access & ~acc_we;
  assign done_wr_c = access &  acc_we;
`endif

endmodule

// File: rtl/mem_sys.sv
// Harvard memory subsystem: independent IM (with loader) and DM channels.
// Define MEM_SYS_PERF_EN to add saturating completion counters.
module mem_sys
  import mem_sys_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned IM_LAT = 1,
  parameter int unsigned DM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                im_req,
  input  logic [ADDR_W-1:0]   im_addr,
  output logic                im_gnt,
  output logic                im_rvalid,
  output logic [DATA_W-1:0]   im_rdata,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_wdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata
`ifdef MEM_SYS_PERF_EN
  ,
  output logic [PERF_W-1:0]   im_acc_cnt,
  output logic [PERF_W-1:0]   dm_rd_cnt,
  output logic [PERF_W-1:0]   dm_wr_cnt
`endif
);

  localparam int unsigned NB = DATA_W / 8;

`ifdef MEM_SYS_PERF_EN
  logic im_done_rd, im_done_wr, dm_done_rd, dm_done_wr;
`endif

  // Fetch channel: read-only requests, loader owns the array while ld_we is high
  mem_chan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(IM_LAT)) u_im (
    .clk       (clk),
    .rst       (rst),
    .req       (im_req),
    .hold      (ld_we),
    .we        (1'b0),
    .be        ({NB{1'b1}}),
    .addr      (im_addr),
    .wdata     ({DATA_W{1'b0}}),
    .ext_we    (ld_we),
    .ext_addr  (ld_addr),
    .ext_wdata (ld_wdata),
    .gnt       (im_gnt),
    .rvalid    (im_rvalid),
    .rdata     (im_rdata)
`ifdef MEM_SYS_PERF_EN
    ,
    .done_rd_c (im_done_rd),
    .done_wr_c (im_done_wr)
`endif
  );

  mem_chan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(DM_LAT)) u_dm (
    .clk       (clk),
    .rst       (rst),
    .req       (dm_req),
    .hold      (1'b0),
    .we        (dm_we),
    .be        (dm_be),
    .addr      (dm_addr),
    .wdata     (dm_wdata),
    .ext_we    (1'b0),
    .ext_addr  ({ADDR_W{1'b0}}),
    .ext_wdata ({DATA_W{1'b0}}),
    .gnt       (dm_gnt),
    .rvalid    (dm_rvalid),
    .rdata     (dm_rdata)
`ifdef MEM_SYS_PERF_EN
    ,
    .done_rd_c (dm_done_rd),
    .done_wr_c (dm_done_wr)
`endif
  );

`ifdef MEM_SYS_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_acc_cnt <= '0;
      dm_rd_cnt  <= '0;
      dm_wr_cnt  <= '0;
    end else begin
      if (im_done_rd | im_done_wr) im_acc_cnt <= sat_inc(im_acc_cnt);
      if (dm_done_rd)              dm_rd_cnt  <= sat_inc(dm_rd_cnt);
      if (dm_done_wr)              dm_wr_cnt  <= sat_inc(dm_wr_cnt);
    end
  end
`endif

endmodule
